// File: rtl/frame_stream_reader.sv
// Raster-order frame reader: fetches IMG_WIDTH x IMG_HEIGHT pixels from a fixed-latency
// frame-buffer port and emits a ready/valid stream with SOF/EOL/EOF. Option: FRAME_REPEAT_EN.
`timescale 1ns/1ps
module frame_stream_reader #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned W          = 8,
   parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [W-1:0]      mem_rd_data,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [W-1:0]      y_data,
   output logic              y_sof,
   output logic              y_eol,
   output logic              y_eof
);

   localparam int unsigned XW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCW = PW + 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [XW-1:0]     COL_LAST  = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]     ROW_LAST  = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [W-1:0]        fifo_mem_q [FIFO_DEPTH];
   logic [W-1:0]        fifo_mem_d [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [FCW-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic                y_valid_q, y_valid_d;
   logic [W-1:0]        y_data_q, y_data_d;
   logic [XW-1:0]       col_q, col_d;
   logic [YW-1:0]       row_q, row_d;

   logic                xfer;
   logic                ret;
   logic                push;
   logic                pop;
   logic                rd_issue;
   logic                last_issue;
   logic                credit_ok;
   logic                eof_hit;
   logic                drained;
   logic [CW-1:0]       in_flight;
   logic [CW-1:0]       occupancy;

   assign xfer       = y_valid_q && y_ready;
   assign ret        = pipe_q[RD_LATENCY-1];
   assign eof_hit    = xfer && y_eof;
   assign last_issue = rd_issue && (rd_addr_q == LAST_ADDR);
   assign drained    = (in_flight == '0) && (fifo_cnt_q == '0) && !y_valid_q;

   // Credits cover every read not yet handed downstream; a pixel leaving this cycle frees one.
   always_comb begin
      in_flight = CW'(mem_rd_en_q);
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
         in_flight = in_flight + CW'(pipe_q[i]);
      end
      occupancy = in_flight + CW'(fifo_cnt_q) + CW'(y_valid_q) - CW'(xfer);
      credit_ok = occupancy < CW'(FIFO_DEPTH);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN: begin
            if (last_issue) begin
`ifdef FRAME_REPEAT_EN
               if (!start) state_d = S_DRAIN;
`else
               state_d = S_DRAIN;
`endif
            end
         end
         S_DRAIN: if (done_q && drained) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: read issue, address walk, busy/done
   always_comb begin
      rd_issue  = 1'b0;
      rd_addr_d = rd_addr_q;
      busy_d    = busy_q;
      done_d    = eof_hit;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               rd_addr_d = '0;
            end
         end
         S_RUN: begin
            rd_issue = credit_ok;
            if (rd_issue) begin
               rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: if (eof_hit) busy_d = 1'b0;
         default: ;
      endcase
      mem_rd_en_d   = rd_issue;
      mem_rd_addr_d = rd_issue ? rd_addr_q : mem_rd_addr_q;
   end

   always_comb begin
      pipe_d[0] = mem_rd_en_q;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Output register is the FIFO head; returning data bypasses storage when it is empty.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      y_valid_d  = y_valid_q;
      y_data_d   = y_data_q;
      push       = 1'b0;
      pop        = 1'b0;
      if (!y_valid_q || xfer) begin
         if (fifo_cnt_q != '0) begin
            y_valid_d = 1'b1;
            y_data_d  = fifo_mem_q[rd_ptr_q];
            pop       = 1'b1;
            push      = ret;
         end else if (ret) begin
            y_valid_d = 1'b1;
            y_data_d  = mem_rd_data;
         end else begin
            y_valid_d = 1'b0;
         end
      end else begin
         push = ret;
      end
      if (push) fifo_mem_d[wr_ptr_q] = mem_rd_data;
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (xfer) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
         end else begin
            col_d = col_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= '0;
         rd_addr_q     <= '0;
         pipe_q        <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         y_valid_q     <= 1'b0;
         y_data_q      <= '0;
         col_q         <= '0;
         row_q         <= '0;
      end else begin
         busy_q        <= busy_d;
         done_q        <= done_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_rd_addr_q <= mem_rd_addr_d;
         rd_addr_q     <= rd_addr_d;
         pipe_q        <= pipe_d;
         fifo_mem_q    <= fifo_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         y_valid_q     <= y_valid_d;
         y_data_q      <= y_data_d;
         col_q         <= col_d;
         row_q         <= row_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign y_valid     = y_valid_q;
   assign y_data      = y_data_q;
   assign y_sof       = y_valid_q && (col_q == '0) && (row_q == '0);
   assign y_eol       = y_valid_q && (col_q == COL_LAST);
   assign y_eof       = y_valid_q && (col_q == COL_LAST) && (row_q == ROW_LAST);

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (fifo_cnt_q == FCW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench for frame_stream_reader on a 4x3 frame; memory returns addr+16 after two cycles.
`timescale 1ns/1ps
module tb_frame_stream_reader;

   localparam int unsigned IW  = 4;
   localparam int unsigned IH  = 3;
   localparam int unsigned PIX = IW * IH;
   localparam int unsigned LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       y_ready = 1'b0;
   logic       busy, done, mem_rd_en, y_valid, y_sof, y_eol, y_eof;
   logic [3:0] mem_rd_addr;
   logic [7:0] mem_rd_data, y_data;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;
   int exp_idx = 0;
   int pix_count = 0;
   int done_count = 0;
   int rd_count = 0;
   int eof_cyc = -100;
   int sof_gap = 0;
   logic        stall_prev = 1'b0;
   logic [10:0] held = '0;

   logic [LAT-1:0] pend_en = '0;
   logic [3:0]     pend_addr [LAT];

   frame_stream_reader #(
      .IMG_WIDTH (IW),
      .IMG_HEIGHT(IH),
      .W         (8),
      .ADDR_W    (4),
      .RD_LATENCY(LAT),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .y_data     (y_data),
      .y_sof      (y_sof),
      .y_eol      (y_eol),
      .y_eof      (y_eof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffer model: keeps returning data regardless of DUT reset
   always @(posedge clk) begin
      pend_en      <= {pend_en[LAT-2:0], mem_rd_en};
      pend_addr[0] <= mem_rd_addr;
      for (int i = 1; i < int'(LAT); i++) pend_addr[i] <= pend_addr[i-1];
   end
   assign mem_rd_data = pend_en[LAT-1] ? (8'(pend_addr[LAT-1]) + 8'd16) : 8'hEE;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Stream scoreboard: reference raster counter, hold-under-stall and done timing
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx    = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 32'(y_valid), 32'd1);
            check("hold_payload", 32'({y_data, y_sof, y_eol, y_eof}), 32'(held));
         end
         if (y_valid && y_ready) begin
            check("pix_data", 32'(y_data), 32'(16 + exp_idx));
            check("pix_sof", 32'(y_sof), 32'(exp_idx == 0));
            check("pix_eol", 32'(y_eol), 32'((exp_idx % IW) == (IW - 1)));
            check("pix_eof", 32'(y_eof), 32'(exp_idx == (PIX - 1)));
            if (y_sof) sof_gap = cyc - eof_cyc;
            if (y_eof) eof_cyc = cyc;
            exp_idx = (exp_idx + 1) % PIX;
            pix_count++;
         end
         stall_prev = y_valid && !y_ready;
         held       = {y_data, y_sof, y_eol, y_eof};
         if (done) begin
            done_count++;
            check("done_after_eof", 32'(cyc - eof_cyc), 32'd1);
         end
         if (mem_rd_en) rd_count++;
      end
   end

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit rnd, input bit start_at_done);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            if (rnd) y_ready = 1'($urandom_range(0, 1));
         end
      end
      #1;
      check(tag, 32'(seen), 32'd1);
      if (seen && start_at_done) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
   endtask

   task automatic wait_pixels(input int base, input int n);
      for (int i = 0; i < 60 && (pix_count - base) < n; i++) begin
         @(negedge clk); #1;
      end
      check("reach_pixels", 32'((pix_count - base) >= n), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int p0, d0, r0, stale;
      bit found;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
      check("rst_valid", 32'(y_valid), 32'd0);
      check("rst_data", 32'(y_data), 32'd0);
      check("rst_markers", 32'({y_sof, y_eol, y_eof}), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Basic frame at full throughput
      y_ready = 1'b1;
      p0 = pix_count; d0 = done_count;
      do_start();
      @(negedge clk);
      check("c0_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("c1_rd_en", 32'(mem_rd_en), 32'd1);
      check("c1_rd_addr", 32'(mem_rd_addr), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (y_valid) found = 1'b1;
      end
      check("first_valid_latency", 32'(cyc - start_cyc), 32'd4);
      wait_done("basic_done", 40, 1'b0, 1'b0);
      check("basic_pixels", 32'(pix_count - p0), 32'd12);
      check("basic_dones", 32'(done_count - d0), 32'd1);
      check("basic_eof_cycle", 32'(eof_cyc - start_cyc), 32'd15);
      @(negedge clk);
      check("basic_idle_busy", 32'(busy), 32'd0);
      check("basic_idle_valid", 32'(y_valid), 32'd0);

      // Backpressure: downstream stalled through cycle 13
      y_ready = 1'b0;
      p0 = pix_count; d0 = done_count; r0 = rd_count;
      do_start();
      repeat (13) @(posedge clk);
      @(negedge clk); #1;
      check("bp_valid", 32'(y_valid), 32'd1);
      check("bp_data", 32'(y_data), 32'd16);
      check("bp_reads", 32'(rd_count - r0), 32'd4);
      check("bp_rd_en_stopped", 32'(mem_rd_en), 32'd0);
      @(posedge clk); #1 y_ready = 1'b1;
      wait_done("bp_done", 60, 1'b0, 1'b0);
      check("bp_pixels", 32'(pix_count - p0), 32'd12);
      check("bp_dones", 32'(done_count - d0), 32'd1);
      check("bp_total_reads", 32'(rd_count - r0), 32'd12);

      // Pseudo-random stalls over five frames
      p0 = pix_count; d0 = done_count;
      for (int f = 0; f < 5; f++) begin
         do_start();
         wait_done("rand_done", 400, 1'b1, 1'b0);
      end
      check("rand_pixels", 32'(pix_count - p0), 32'd60);
      check("rand_dones", 32'(done_count - d0), 32'd5);

      // Start while busy and start coincident with done are both ignored
      y_ready = 1'b1;
      @(posedge clk); #1;
      p0 = pix_count; d0 = done_count; r0 = rd_count;
      do_start();
      wait_pixels(p0, 5);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("busy_start_done", 40, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      #1;
      check("busy_start_pixels", 32'(pix_count - p0), 32'd12);
      check("busy_start_dones", 32'(done_count - d0), 32'd1);
      check("busy_start_reads", 32'(rd_count - r0), 32'd12);
      check("busy_start_idle", 32'(busy), 32'd0);

      // Reset in the middle of a frame
      p0 = pix_count;
      do_start();
      wait_pixels(p0, 6);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("mid_rst_addr", 32'(mem_rd_addr), 32'd0);
      check("mid_rst_valid", 32'(y_valid), 32'd0);
      check("mid_rst_data", 32'(y_data), 32'd0);
      check("mid_rst_markers", 32'({y_sof, y_eol, y_eof, done}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (y_valid || mem_rd_en || busy) stale++;
      end
      check("no_stale_after_reset", 32'(stale), 32'd0);
      p0 = pix_count; d0 = done_count;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (y_valid) found = 1'b1;
      end
      check("post_rst_first_data", 32'(y_data), 32'd16);
      check("post_rst_first_sof", 32'(y_sof), 32'd1);
      wait_done("post_rst_done", 40, 1'b0, 1'b0);
      check("post_rst_pixels", 32'(pix_count - p0), 32'd12);
      check("post_rst_dones", 32'(done_count - d0), 32'd1);

`ifdef FRAME_REPEAT_EN
      // Back-to-back frames while start is held across the last read
      @(posedge clk); #1;
      p0 = pix_count; d0 = done_count;
      start = 1'b1;
      repeat (16) @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 80 && (done_count - d0) < 2; i++) begin
         @(negedge clk); #1;
      end
      check("rep_dones", 32'(done_count - d0), 32'd2);
      check("rep_pixels", 32'(pix_count - p0), 32'd24);
      check("rep_sof_follows_eof", 32'(sof_gap), 32'd1);
      repeat (4) @(negedge clk);
      check("rep_idle_busy", 32'(busy), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Pixel stream source for the pattern-recognition pipeline.
- Reads one IMG_WIDTH x IMG_HEIGHT frame from a fixed-latency frame-buffer read port, in raster order.
- Emits the frame as a ready/valid pixel stream with SOF/EOL/EOF markers, suitable to drive the convolution filter input.
- A credit-limited internal FIFO absorbs memory read latency so downstream backpressure never drops or duplicates pixels.

Parameters:
- IMG_WIDTH, 640, pixels per row.
- IMG_HEIGHT, 480, rows per frame.
- W, 8, pixel width in bits.
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), frame-buffer address width.
- RD_LATENCY, 2, fixed cycles from mem_rd_en to valid mem_rd_data (1..8).
- FIFO_DEPTH, 4, output FIFO entries; power of two, must be >= RD_LATENCY+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  start-of-frame request, sampled in IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final pixel handshake
- mem_rd_en  out  1  read request to the frame buffer
- mem_rd_addr  out  ADDR_W  read address, linear y*IMG_WIDTH+x
- mem_rd_data  in  W  read data, valid exactly RD_LATENCY cycles after mem_rd_en
- y_valid  out  1  output pixel valid
- y_ready  in  1  downstream ready
- y_data  out  W  pixel value
- y_sof  out  1  marks pixel (0,0)
- y_eol  out  1  marks x = IMG_WIDTH-1
- y_eof  out  1  marks the last pixel of the frame

Behaviour:
- Reset values: all outputs are 0. FSM is IDLE. FIFO is empty. Counters are 0.
- Reset mid-frame: asynchronously aborts the frame. Data still returning from memory after reset release is ignored via the in-flight tracking shift register, which is also cleared.
- FSM has three states: IDLE, RUN, DRAIN.
  - IDLE: start=1 moves to RUN, sets busy=1 and clears the read address.
  - RUN: issues one read per cycle while (in_flight + fifo_count) < FIFO_DEPTH. The read after address W*H-1 is issued moves the FSM to DRAIN.
  - DRAIN: when the FIFO is empty, in_flight=0 and the last pixel has been handshaken, pulses done for one cycle, clears busy and returns to IDLE.
- start while busy is ignored.
- in_flight is the count of reads issued but not yet returned, tracked by a RD_LATENCY-deep valid shift register.
- Returned data is written into the FIFO in the cycle mem_rd_data is valid. The credit rule guarantees the FIFO never overflows; overflow is a verification assertion.
- Timing: start high at edge N gives mem_rd_en=1 with addr 0 in cycle N+1. Data enters the FIFO at cycle N+1+RD_LATENCY. The earliest y_valid is cycle N+2+RD_LATENCY, since the output is registered.
- Handshake: a transfer occurs when y_valid && y_ready.
  - While y_valid=1 and y_ready=0, y_data and all markers hold stable.
  - y_valid never deasserts without a transfer.
  - Zero-bubble throughput of 1 pixel/cycle when y_ready is held at 1.
- Output-side x/y counters advance on each transfer and wrap at IMG_WIDTH-1 and IMG_HEIGHT-1.
- Markers are combinational from these counters and are qualified by y_valid:
  - y_sof at (0,0).
  - y_eol at x = IMG_WIDTH-1.
  - y_eof at (IMG_WIDTH-1, IMG_HEIGHT-1).
- Simultaneous FIFO write and read when the FIFO is full-minus-zero is legal; count is unchanged.
- done and start in the same cycle: start is ignored because the FSM is not yet IDLE.

Optional Feature:
- Macro: FRAME_REPEAT_EN.
- Defined: if start=1 in the cycle the last address is issued, the read address wraps to 0 and the FSM stays in RUN with no bubble.
  - done still pulses after each frame's final handshake.
  - busy stays high.
  - Output counters wrap, so y_sof of the next frame may directly follow y_eof.
- Undefined: start is ignored outside IDLE, and every frame requires a new start after done.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, RD_LATENCY=2, FIFO_DEPTH=4; memory holds data = addr+16):
- Basic frame: start pulse, y_ready=1 → 12 pixels 16..27 on consecutive cycles.
  - First y_valid at 4 cycles after start.
  - y_sof on 16; y_eol on 19, 23, 27; y_eof on 27.
  - done pulses one cycle after the transfer of 27.
- Backpressure: y_ready=0 for cycles 4..13 after start → y_valid holds with y_data=16.
  - mem_rd_en stops after 4 outstanding+buffered reads.
  - On release, pixels resume 16..27 with no loss or duplicate.
- Random stall: y_ready toggled pseudo-randomly over 5 frames → the output sequence matches the reference counter exactly, and the no-overflow assertion never fires.
- Start while busy: second start pulse at pixel 5 → ignored; exactly 12 pixels and one done.
- Reset mid-frame: assert rst_n=0 after pixel 6, release, then start → all outputs are 0 during reset, and the new frame begins at 16 with y_sof. No stale data appears.
- FRAME_REPEAT_EN: hold start=1 → 24 pixels back-to-back, 16..27 then 16..27. y_eof on the 12th pixel is followed immediately by y_sof, with two done pulses.
